pipelined_addsub: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit ripple adder.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/addsub_slice.sv | 34 +++
 rtl/full_adder.sv | 19 +
 rtl/pipelined_addsub.sv | 146 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module : alu_pkg
// Desc   : Op encoding and carry-seed helper for the add/subtract unit
// Rev    : 1.0
//==============================================================================
package alu_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_ADC = 2'b10;
    localparam logic [OP_W-1:0] OP_SBB = 2'b11;

    // op[0] selects inversion of b; SUB is a + ~b + 1, SBB takes the caller's carry
    function automatic logic carry_seed(input logic [OP_W-1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
//==============================================================================
// Module : addsub_slice
// Desc   : Combinational SW-bit ripple adder built from full_adder cells
// Rev    : 1.0
//==============================================================================
module addsub_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout
);

    logic [SW:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (s[i]),
            .co (w_c[i+1])
        );
    end

    assign cout = w_c[SW];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
//==============================================================================
// Module : full_adder
// Desc   : One-bit full adder cell
// Rev    : 1.0
//==============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
//==============================================================================
// Module : pipelined_addsub
// Desc   : WIDTH-bit add/sub split into STAGES registered carry slices, with
//          carry/overflow/zero flags and a whole-pipe valid/ready stall
// Rev    : 1.0
//==============================================================================
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_SW   = WIDTH / STAGES;
    localparam int c_LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_p;
    logic             w_c0;

    assign w_b_p    = op[0] ? ~b : b;
    assign w_c0     = carry_seed(op, cin);
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Stage k sums slice k; untouched upper slices shift down in g_skew so the
    // active slice always sits at bit 0, and finished slices accumulate in r_lo.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_REM = WIDTH - k * c_SW;

        logic [c_REM-1:0]        w_a_rem;
        logic [c_REM-1:0]        w_b_rem;
        logic                    w_c_in;
        logic                    w_v_in;
        logic [c_SW-1:0]         w_s;
        logic                    w_c_out;
        logic [(k+1)*c_SW-1:0]   w_lo;
        logic [(k+1)*c_SW-1:0]   r_lo;
        logic                    r_c;
        logic                    r_vld;

        if (k == 0) begin : g_head
            assign w_a_rem = a;
            assign w_b_rem = w_b_p;
            assign w_c_in  = w_c0;
            assign w_v_in  = in_valid;
            assign w_lo    = w_s;
        end else begin : g_body
            assign w_a_rem = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_rem = g_stage[k-1].g_skew.r_b_hi;
            assign w_c_in  = g_stage[k-1].r_c;
            assign w_v_in  = g_stage[k-1].r_vld;
            assign w_lo    = {w_s, g_stage[k-1].r_lo};
        end

        addsub_slice #(
            .SW (c_SW)
        ) u_slice (
            .a    (w_a_rem[c_SW-1:0]),
            .b    (w_b_rem[c_SW-1:0]),
            .cin  (w_c_in),
            .s    (w_s),
            .cout (w_c_out)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lo  <= '0;
                r_c   <= 1'b0;
                r_vld <= 1'b0;
            end else if (w_en) begin
                r_lo  <= w_lo;
                r_c   <= w_c_out;
                r_vld <= w_v_in;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [c_REM-c_SW-1:0] r_a_hi;
            logic [c_REM-c_SW-1:0] r_b_hi;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_en) begin
                    r_a_hi <= w_a_rem[c_REM-1:c_SW];
                    r_b_hi <= w_b_rem[c_REM-1:c_SW];
                end
            end
        end
    end

    // Flags come from the last slice, whose top bits are the operand MSBs.
    logic w_a_msb;
    logic w_b_msb;
    logic w_s_msb;
    logic w_ovf_nxt;
    logic w_zero_nxt;
    logic r_ovf;
    logic r_zero;

    assign w_a_msb    = g_stage[c_LAST].w_a_rem[c_SW-1];
    assign w_b_msb    = g_stage[c_LAST].w_b_rem[c_SW-1];
    assign w_s_msb    = g_stage[c_LAST].w_s[c_SW-1];
    assign w_ovf_nxt  = (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
    assign w_zero_nxt = (g_stage[c_LAST].w_lo == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign sum       = g_stage[c_LAST].r_lo;
    assign cout      = g_stage[c_LAST].r_c;
    assign out_valid = g_stage[c_LAST].r_vld;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
//==============================================================================
// Module : tb_pipelined_addsub
// Desc   : Scoreboard bench for the 32/4 and 8/1 configurations
// Rev    : 1.0
//==============================================================================
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv32, ir32, cin32, ov32, or32, co32, ovf32, z32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, sum32;
    logic        iv8, ir8, cin8, ov8, or8, co8, ovf8, z8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, sum8;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
        .sum(sum32), .cout(co32), .ovf(ovf32), .zero(z32)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(co8), .ovf(ovf8), .zero(z8)
    );

    // expected beat: {zero, ovf, cout, sum[31:0]}
    logic [34:0] q32[$];
    logic [34:0] q8[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_del32  = 0;
    int n_del8   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [34:0] model(input int w, input logic [1:0] o,
                                          input logic [31:0] xa, input logic [31:0] xb,
                                          input logic xc);
        logic [63:0] mask, am, bp, full, s;
        logic        v;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'b0, xa} & mask;
        bp   = (o[0] ? ~{32'b0, xb} : {32'b0, xb}) & mask;
        full = am + bp + {63'b0, (o[1] ? xc : o[0])};
        s    = full & mask;
        v    = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
        return {(s == 64'd0), v, full[w], s[31:0]};
    endfunction

    task automatic step32(input logic iv, input logic [1:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic xc, input logic ordy,
                          input logic [34:0] exp_res, output logic acc);
        logic [34:0] e;
        @(negedge clk);
        iv32 = iv; op32 = o; a32 = xa; b32 = xb; cin32 = xc; or32 = ordy;
        #1;
        if (ov32 && or32) begin
            if (q32.size() == 0) begin
                check_eq("extra_beat32", 64'(ov32), 64'd0);
            end else begin
                e = q32.pop_front();
                n_del32++;
                check_eq("sum32",  64'(sum32), 64'(e[31:0]));
                check_eq("cout32", 64'(co32),  64'(e[32]));
                check_eq("ovf32",  64'(ovf32), 64'(e[33]));
                check_eq("zero32", 64'(z32),   64'(e[34]));
            end
        end
        acc = iv32 && ir32;
        if (acc) q32.push_back(exp_res);
    endtask

    task automatic step8(input logic iv, input logic [1:0] o, input logic [7:0] xa,
                         input logic [7:0] xb, input logic xc, input logic ordy,
                         input logic [34:0] exp_res, output logic acc);
        logic [34:0] e;
        @(negedge clk);
        iv8 = iv; op8 = o; a8 = xa; b8 = xb; cin8 = xc; or8 = ordy;
        #1;
        if (ov8 && or8) begin
            if (q8.size() == 0) begin
                check_eq("extra_beat8", 64'(ov8), 64'd0);
            end else begin
                e = q8.pop_front();
                n_del8++;
                check_eq("sum8",  64'(sum8), 64'(e[7:0]));
                check_eq("cout8", 64'(co8),  64'(e[32]));
                check_eq("ovf8",  64'(ovf8), 64'(e[33]));
                check_eq("zero8", 64'(z8),   64'(e[34]));
            end
        end
        acc = iv8 && ir8;
        if (acc) q8.push_back(exp_res);
    endtask

    task automatic drain32();
        logic acc;
        for (int i = 0; i < 40 && q32.size() > 0; i++)
            step32(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
        check_eq("drain32", 64'(q32.size()), 64'd0);
    endtask

    task automatic drain8();
        logic acc;
        for (int i = 0; i < 40 && q8.size() > 0; i++)
            step8(1'b0, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1, 35'd0, acc);
        check_eq("drain8", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [34:0] hold;
        logic [31:0] sa[10], sb[10];
        logic        sc[10];
        int          lat, idx, del0;

        rst_n = 1'b0;
        iv32 = 0; op32 = 0; a32 = 0; b32 = 0; cin32 = 0; or32 = 1;
        iv8  = 0; op8  = 0; a8  = 0; b8  = 0; cin8  = 0; or8  = 1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ov32",  64'(ov32),  64'd0);
        check_eq("rst_ir32",  64'(ir32),  64'd1);
        check_eq("rst_sum32", 64'(sum32), 64'd0);
        check_eq("rst_flg32", 64'({co32, ovf32, z32}), 64'd0);
        check_eq("rst_ov8",   64'(ov8),   64'd0);
        check_eq("rst_sum8",  64'({sum8, co8, ovf8, z8}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD wrap and first-beat latency
        step32(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0}, acc);
        check_eq("t1_accept", 64'(acc), 64'd1);
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            step32(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
            if (ov32) lat = n;
        end
        check_eq("lat32", 64'(lat), 64'd4);
        drain32();

        // SUB overflow, ADC overflow, SBB borrow
        step32(1'b1, 2'b01, 32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}, acc);
        step32(1'b1, 2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 32'h8000_0000}, acc);
        step32(1'b1, 2'b11, 32'h5, 32'h5, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF}, acc);
        drain32();

        // Single-stage configuration
        step8(1'b1, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0}, acc);
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            step8(1'b0, 2'b00, 8'd0, 8'd0, 1'b0, 1'b1, 35'd0, acc);
            if (ov8) lat = n;
        end
        check_eq("lat8", 64'(lat), 64'd1);
        step8(1'b1, 2'b01, 8'h80, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 32'h7F}, acc);
        step8(1'b1, 2'b11, 8'h00, 8'h01, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFE}, acc);
        drain8();

        // Stream of 10 with a 3-cycle downstream stall
        for (int i = 0; i < 10; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; del0 = n_del32; hold = '0;
        for (int s = 0; s < 40 && idx < 10; s++) begin
            step32(1'b1, 2'(idx), sa[idx], sb[idx], sc[idx], !(s >= 6 && s <= 8),
                   model(32, 2'(idx), sa[idx], sb[idx], sc[idx]), acc);
            if (s == 6) begin
                check_eq("stall_ir", 64'(ir32), 64'd0);
                check_eq("stall_ov", 64'(ov32), 64'd1);
                hold = {z32, ovf32, co32, sum32};
            end else if (s == 7 || s == 8) begin
                check_eq("stall_ir", 64'(ir32), 64'd0);
                check_eq("stall_hold", 64'({z32, ovf32, co32, sum32}), 64'(hold));
            end
            if (acc) idx++;
        end
        check_eq("stream_acc", 64'(idx), 64'd10);
        drain32();
        check_eq("stream_del", 64'(n_del32 - del0), 64'd10);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++)
            step32(1'b1, 2'b00, 32'(i + 1), 32'd7, 1'b0, 1'b1, model(32, 2'b00, 32'(i + 1), 32'd7, 1'b0), acc);
        @(negedge clk);
        iv32 = 1'b0;
        rst_n = 1'b0;
        q32.delete();
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ov", 64'(ov32), 64'd0);
        check_eq("post_rst_ir", 64'(ir32), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step32(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 35'd0, acc);
            check_eq("flush_ov", 64'(ov32), 64'd0);
        end

        // Random traffic on both configurations
        fork
            begin
                logic        a_r;
                logic [1:0]  o_r;
                logic [31:0] x_r, y_r;
                logic        c_r;
                for (int i = 0; i < 10000; i++) begin
                    o_r = 2'($urandom_range(0, 3));
                    x_r = $urandom; y_r = $urandom;
                    if (i % 7 == 0) y_r = x_r;
                    c_r = 1'($urandom_range(0, 1));
                    step32($urandom_range(0, 3) != 0, o_r, x_r, y_r, c_r,
                           $urandom_range(0, 3) != 0, model(32, o_r, x_r, y_r, c_r), a_r);
                end
                drain32();
            end
            begin
                logic       a_r;
                logic [1:0] o_r;
                logic [7:0] x_r, y_r;
                logic       c_r;
                for (int i = 0; i < 3000; i++) begin
                    o_r = 2'($urandom_range(0, 3));
                    x_r = 8'($urandom); y_r = 8'($urandom);
                    c_r = 1'($urandom_range(0, 1));
                    step8($urandom_range(0, 3) != 0, o_r, x_r, y_r, c_r,
                          $urandom_range(0, 3) != 0, model(8, o_r, {24'b0, x_r}, {24'b0, y_r}, c_r), a_r);
                end
                drain8();
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
